transform_4x4_seq: RTL and testbench
====================================

// Module: transform_4x4_seq
// PURPOSE
// - Sequences one transform_butterfly instance through a full 2-D 4x4 inverse transform.
// - The first pass operates on rows; the second operates on the transposed intermediate (columns).
// - In residual mode the block applies the (x+32)>>>6 rounding; in DHT mode (luma/chroma DC Hadamard) it outputs unrounded results.
// - Sits between the inverse-quant stage (upstream, valid/ready) and residual reconstruction (downstream, valid/ready).
// PARAMETERS
// - DW           16  coefficient/result width, signed; must match the butterfly width.
// - ROUND_SHIFT  6   final right shift in residual mode; rounding constant = 1<<(ROUND_SHIFT-1).
// PORTS
// - clk        in   1      clock
// - rst_n      in   1      asynchronous, active-low reset
// - in_valid   in   1      input block valid
// - in_ready   out  1      block accepted on in_valid&in_ready
// - in_dht     in   1      1 = Hadamard (DC) block; 0 = residual IDCT block
// - in_coef    in   16*DW  coefficients; element k=4*r+c occupies bits [k*DW +: DW]
// - out_valid  out  1      result block valid
// - out_ready  in   1      downstream accepts on out_valid&out_ready
// - out_data   out  16*DW  results; same element packing as in_coef
// - busy       out  1      high in any state other than IDLE
// - bf_ena     out  1      butterfly ena
// - bf_dht_sel out  1      butterfly DHT_sel; equals the latched in_dht
// - bf_in      out  16*DW  butterfly_in_0..15, packed
// - bf_out     in   16*DW  butterfly_out_0..15, packed; valid the cycle after bf_ena
// BEHAVIOUR
// - Reset values: state=IDLE; out_valid=0; out_data=0; bf_ena=0; block/tmp registers=0. in_ready=1 after reset.
// - in_ready = (state==IDLE). No new block is accepted while a result is pending.
// - FSM states and transitions:
//   - IDLE: on handshake, latch in_coef into blk and in_dht into dht, then go to ROW.
//   - ROW: bf_ena=1, bf_in=blk; go to ROW_CAP.
//   - ROW_CAP: tmp <= bf_out; go to COL.
//   - COL: bf_ena=1, bf_in[4*c+r]=tmp[4*r+c] (transpose); go to COL_CAP.
//   - COL_CAP: out_data[4*r+c] <= fin(bf_out[4*c+r]); go to OUT.
//   - OUT: out_valid=1, out_data held stable until out_ready; on handshake go to IDLE.
// - bf_ena=0 outside ROW/COL. bf_in is driven only from registers, so there is no combinational path through the butterfly into the FSM.
// - Latency: a handshake in cycle 0 gives out_valid=1 in cycle 5. Minimum throughput is one block per 6 cycles.
// - fin(x):
//   - dht=1: x unchanged.
//   - dht=0: sign-extend x to DW+1, add 1<<(ROUND_SHIFT-1), arithmetic shift right by ROUND_SHIFT, take the low DW bits.
// - Intermediate sums wrap modulo 2^DW, exactly as the butterfly does; no saturation.
// - Backpressure: while out_ready=0 in OUT, every register holds its value and in_ready stays 0.
// - in_valid is ignored outside IDLE. in_coef/in_dht are sampled only at the handshake.
// - Reset mid-operation: the block returns to IDLE immediately, out_valid drops, and the partial block is discarded.
// CONFIGURATION
// - TRANS_ZERO_SKIP_EN defined:
//   - At the IDLE handshake, if all 16 in_coef elements are 0, go directly to OUT with out_data=0.
//   - bf_ena is never asserted for that block. Latency is 1 cycle (out_valid in cycle 1).
// - TRANS_ZERO_SKIP_EN undefined:
//   - All-zero blocks take the normal path and produce out_data=0 with 5-cycle latency.
//   - The zero-detect logic is not synthesised.
// TESTING
// - Residual DC: in_coef[0]=64, others 0, in_dht=0 -> all 16 out elements = 1; out_valid in cycle 5.
// - Negative rounding: in_coef[0]=-64, others 0, in_dht=0 -> all 16 out elements = -1 (0xFFFF).
// - DHT: in_coef[0]=4, others 0, in_dht=1 -> all 16 out = 4; bf_dht_sel=1 during ROW and COL.
// - Backpressure: out_ready=0 for 3 cycles in OUT -> out_valid=1 and out_data stable, in_ready=0; ready=1 completes the handshake and in_ready=1 the next cycle.
// - Reset asserted in ROW_CAP -> out_valid=0, bf_ena=0, in_ready=1 after release; the next block computes correctly.
// - All-zero block -> with TRANS_ZERO_SKIP_EN: out_valid in cycle 1, bf_ena never high; without it: out_valid in cycle 5, out_data=0.

Source files
------------

// File: rtl/transform_4x4_seq.sv
// Sequences an external 4x4 butterfly through a row pass and a transposed column pass.
// Define TRANS_ZERO_SKIP_EN to bypass the butterfly for all-zero input blocks.
module transform_4x4_seq #(
   parameter int DW          = 16,
   parameter int ROUND_SHIFT = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_dht,
   input  logic [16*DW-1:0] in_coef,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [16*DW-1:0] out_data,
   output logic             busy,
   output logic             bf_ena,
   output logic             bf_dht_sel,
   output logic [16*DW-1:0] bf_in,
   input  logic [16*DW-1:0] bf_out
);

   localparam logic signed [DW:0] RND = (DW+1)'(1 << (ROUND_SHIFT - 1));

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROW,
      S_ROW_CAP,
      S_COL,
      S_COL_CAP,
      S_OUT
   } state_t;

   state_t state_reg, state_next;

   logic [16*DW-1:0] blk_reg;
   logic [16*DW-1:0] tmp_reg;
   logic [16*DW-1:0] out_data_reg;
   logic             dht_reg;
   logic [16*DW-1:0] col_in;
   logic [16*DW-1:0] fin_out;

`ifdef TRANS_ZERO_SKIP_EN
   logic coef_zero;
   assign coef_zero = (in_coef == '0);
`endif

   // Transpose for the column pass, and final rounding of the column results.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_elem
         localparam int R = gi / 4;
         localparam int C = gi % 4;
         logic [DW-1:0]        cap;
         logic signed [DW:0]   cap_ext;
         assign col_in[(4*C+R)*DW +: DW] = tmp_reg[(4*R+C)*DW +: DW];
         assign cap     = bf_out[(4*C+R)*DW +: DW];
         assign cap_ext = {cap[DW-1], cap};
         assign fin_out[(4*R+C)*DW +: DW] =
            dht_reg ? cap : DW'((cap_ext + RND) >>> ROUND_SHIFT);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      bf_ena     = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
`ifdef TRANS_ZERO_SKIP_EN
               state_next = coef_zero ? S_OUT : S_ROW;
`else
               state_next = S_ROW;
`endif
            end
         end
         S_ROW: begin
            bf_ena     = 1'b1;
            state_next = S_ROW_CAP;
         end
         S_ROW_CAP: state_next = S_COL;
         S_COL: begin
            bf_ena     = 1'b1;
            state_next = S_COL_CAP;
         end
         S_COL_CAP: state_next = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_reg      <= '0;
         tmp_reg      <= '0;
         out_data_reg <= '0;
         dht_reg      <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (in_valid) begin
                  blk_reg <= in_coef;
                  dht_reg <= in_dht;
`ifdef TRANS_ZERO_SKIP_EN
                  if (coef_zero) begin
                     out_data_reg <= '0;
                  end
`endif
               end
            end
            S_ROW_CAP: tmp_reg      <= bf_out;
            S_COL_CAP: out_data_reg <= fin_out;
            default: ;
         endcase
      end
   end

   // Butterfly inputs come straight from registers; no path from bf_out back into the FSM.
   assign bf_in      = (state_reg == S_COL) ? col_in : blk_reg;
   assign bf_dht_sel = dht_reg;
   assign out_data   = out_data_reg;

endmodule

// File: tb/tb_transform_4x4_seq.sv
// Randomized scoreboard bench for transform_4x4_seq with a behavioural butterfly
// and a matrix-form reference model of the full 2-D transform.
module tb_transform_4x4_seq;
   localparam int DW = 16;
   localparam int NW = 16 * DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_dht = 1'b0;
   logic [NW-1:0] in_coef = '0;
   logic          out_ready = 1'b1;
   logic          in_ready, out_valid, busy, bf_ena, bf_dht_sel;
   logic [NW-1:0] out_data, bf_in;
   logic [NW-1:0] bf_out = '0;

   typedef struct {
      logic [NW-1:0] data;
      bit            dht;
      int            hs_cyc;
      int            lat;
      int            ena;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   bp_mode = 0;

   int sgn [4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
   bit half [4][4] = '{'{0, 0, 0, 1}, '{0, 1, 0, 0}, '{0, 1, 0, 0}, '{0, 0, 0, 1}};

   transform_4x4_seq #(.DW(DW), .ROUND_SHIFT(6)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_dht(in_dht), .in_coef(in_coef), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy), .bf_ena(bf_ena), .bf_dht_sel(bf_dht_sel),
      .bf_in(bf_in), .bf_out(bf_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [NW-1:0] rnd_vec();
      logic [NW-1:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // Butterfly stand-in: four independent 4-point stages, output valid one cycle after bf_ena.
   function automatic logic [NW-1:0] bfly(input logic [NW-1:0] x, input logic dht);
      logic [NW-1:0] y;
      logic signed [DW-1:0] a0, a1, a2, a3, e0, e1, e2, e3;
      for (int g = 0; g < 4; g++) begin
         a0 = x[(4*g+0)*DW +: DW];
         a1 = x[(4*g+1)*DW +: DW];
         a2 = x[(4*g+2)*DW +: DW];
         a3 = x[(4*g+3)*DW +: DW];
         e0 = a0 + a2;
         e1 = a0 - a2;
         e2 = dht ? (a1 - a3) : ((a1 >>> 1) - a3);
         e3 = dht ? (a1 + a3) : (a1 + (a3 >>> 1));
         y[(4*g+0)*DW +: DW] = e0 + e3;
         y[(4*g+1)*DW +: DW] = e1 + e2;
         y[(4*g+2)*DW +: DW] = e1 - e2;
         y[(4*g+3)*DW +: DW] = e0 - e3;
      end
      return y;
   endfunction

   always @(posedge clk) bf_out <= bf_ena ? bfly(bf_in, bf_dht_sel) : rnd_vec();

   // Reference: one 4-point transform as a signed matrix product with half-weight taps.
   function automatic logic [4*DW-1:0] ref_vec(input logic [4*DW-1:0] v, input bit dht);
      logic [4*DW-1:0] o;
      int acc, a;
      for (int i = 0; i < 4; i++) begin
         acc = 0;
         for (int j = 0; j < 4; j++) begin
            a = int'(signed'(v[j*DW +: DW]));
            if (!dht && half[i][j]) a = a >>> 1;
            acc += sgn[i][j] * a;
         end
         o[i*DW +: DW] = acc[DW-1:0];
      end
      return o;
   endfunction

   function automatic logic [NW-1:0] ref2d(input logic [NW-1:0] c, input bit dht);
      logic [NW-1:0]   tmp, res;
      logic [4*DW-1:0] col, ocol;
      int x;
      for (int r = 0; r < 4; r++) tmp[r*4*DW +: 4*DW] = ref_vec(c[r*4*DW +: 4*DW], dht);
      for (int cc = 0; cc < 4; cc++) begin
         for (int r = 0; r < 4; r++) col[r*DW +: DW] = tmp[(4*r+cc)*DW +: DW];
         ocol = ref_vec(col, dht);
         for (int r = 0; r < 4; r++) begin
            x = int'(signed'(ocol[r*DW +: DW]));
            if (!dht) x = (x + 32) >>> 6;
            res[(4*r+cc)*DW +: DW] = x[DW-1:0];
         end
      end
      return res;
   endfunction

   task automatic chk(input string name, input logic [NW-1:0] got, input logic [NW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (bp_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: pops the scoreboard on each output handshake and checks protocol invariants.
   int            first_cyc = 0;
   int            ena_cnt = 0;
   bit            seen = 0, prev_hold = 0, after_hs = 0;
   logic [NW-1:0] prev_data;
   exp_t          e_mon;

   always @(negedge clk) begin
      if (!rst_n) begin
         seen = 0; ena_cnt = 0; prev_hold = 0; after_hs = 0;
      end else begin
         chk("busy_vs_ready", NW'(busy), NW'(!in_ready));
         if (bf_ena) begin
            ena_cnt++;
            if (sb.size() > 0) chk("bf_dht_sel", NW'(bf_dht_sel), NW'(sb[0].dht));
         end
         if (prev_hold) begin
            chk("hold_valid", NW'(out_valid), NW'(1));
            chk("hold_data", out_data, prev_data);
         end
         if (after_hs) begin
            chk("ready_after_hs", NW'(in_ready), NW'(1));
            after_hs = 0;
         end
         prev_hold = 0;
         if (out_valid) begin
            if (!seen) first_cyc = cyc;
            seen = 1;
            chk("ready_while_out", NW'(in_ready), NW'(0));
            if (out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_out", NW'(out_valid), NW'(0));
               end else begin
                  e_mon = sb.pop_front();
                  $display("blk dht=%0d lat=%0d ena=%0d out=%h", e_mon.dht,
                           first_cyc - e_mon.hs_cyc, ena_cnt, out_data);
                  chk("out_data", out_data, e_mon.data);
                  chk("latency", NW'(first_cyc - e_mon.hs_cyc), NW'(e_mon.lat));
                  chk("bf_ena_count", NW'(ena_cnt), NW'(e_mon.ena));
               end
               seen = 0; ena_cnt = 0; after_hs = 1;
            end else begin
               prev_hold = 1;
               prev_data = out_data;
            end
         end
      end
   end

   // Issues one block; returns at the start of cycle 2 after the handshake.
   task automatic send(input logic [NW-1:0] c, input bit d, input logic [NW-1:0] exp);
      exp_t e;
      int   n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_coef = c; in_dht = d;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 300) begin
            chk("accept_timeout", NW'(in_ready), NW'(1));
            break;
         end
      end
      e.data = exp; e.dht = d; e.hs_cyc = cyc; e.lat = 5; e.ena = 2;
`ifdef TRANS_ZERO_SKIP_EN
      if (c == '0) begin e.lat = 1; e.ena = 0; end
`endif
      sb.push_back(e);
      @(posedge clk); #1;
      in_coef = rnd_vec(); in_dht = ~d;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb.size() != 0 || !in_ready) begin
         @(negedge clk);
         n++;
         if (n > 300) begin
            chk("drain_timeout", NW'(sb.size()), NW'(0));
            sb.delete();
            break;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   logic [NW-1:0] c, ones, mones, fours;
   bit            d;
   int            n;

   initial begin
      ones  = {16{16'h0001}};
      mones = {16{16'hFFFF}};
      fours = {16{16'h0004}};
      #23;
      chk("rst_out_valid", NW'(out_valid), NW'(0));
      chk("rst_out_data", out_data, '0);
      chk("rst_bf_ena", NW'(bf_ena), NW'(0));
      chk("rst_in_ready", NW'(in_ready), NW'(1));
      @(posedge clk); #1 rst_n = 1'b1;

      c = '0; c[DW-1:0] = 16'd64;
      send(c, 1'b0, ones); wait_idle();
      c = '0; c[DW-1:0] = 16'hFFC0;
      send(c, 1'b0, mones); wait_idle();
      c = '0; c[DW-1:0] = 16'd4;
      send(c, 1'b1, fours); wait_idle();
      send('0, 1'b0, '0); wait_idle();

      // Backpressure: hold out_ready low for several OUT cycles.
      bp_mode = 2;
      c = '0; c[DW-1:0] = 16'd64;
      send(c, 1'b0, ones);
      n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      chk("bp_valid_held", NW'(out_valid), NW'(1));
      chk("bp_in_ready", NW'(in_ready), NW'(0));
      bp_mode = 0;
      wait_idle();

      // Reset while in ROW_CAP discards the partial block.
      c = rnd_vec();
      send(c, 1'b0, ref2d(c, 1'b0));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", NW'(out_valid), NW'(0));
      chk("mid_rst_bf_ena", NW'(bf_ena), NW'(0));
      chk("mid_rst_in_ready", NW'(in_ready), NW'(1));
      sb.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", NW'(in_ready), NW'(1));
      c = '0; c[DW-1:0] = 16'd64;
      send(c, 1'b0, ones); wait_idle();

      bp_mode = 1;
      for (int b = 0; b < 60; b++) begin
         for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) == 0) c[k*DW +: DW] = DW'($urandom());
            else c[k*DW +: DW] = DW'(int'($urandom_range(0, 600)) - 300);
         end
         if (b % 17 == 5) c = '0;
         d = bit'($urandom_range(0, 1));
         send(c, d, ref2d(c, d));
         if ($urandom_range(0, 1) == 1) wait_idle();
      end
      bp_mode = 0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
